// File: rtl/run_control_unit.sv
// CPU run/reset controller: button sync + debounce, timed CPU reset, RUN/STEP clock enable.
// Latency: raw button to btn_level is DEBOUNCE_CYCLES+3 cycles; all outputs registered; no backpressure.
module run_control_unit #(
   parameter int NUM_BTNS          = 2,
   parameter int DEBOUNCE_CYCLES   = 65535,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int LONG_PRESS_CYCLES = 8000000,
   parameter int CNT_W             = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn,
   output logic                cpu_reset_n,
   output logic                cpu_clk_en,
   output logic                step_mode,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_event
);

   localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_PRESS_CYCLES);

   typedef enum logic {
      HOLD   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   logic [NUM_BTNS-1:0] sync_a;
   logic [NUM_BTNS-1:0] sync_b;
   logic [NUM_BTNS-1:0] sample;

   // Synchronisers idle at the released (high) level so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_a <= '1;
         sync_b <= '1;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
      end
   end

   assign sample = ~sync_b;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;
      logic             level;
      logic             evt;

      always_ff @(posedge clk) begin
         if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
            evt   <= 1'b0;
         end else begin
            evt <= 1'b0;
            if (sample[i] == level) begin
               cnt <= '0;
            end else if (cnt == DEB_MAX) begin
               cnt   <= '0;
               level <= sample[i];
               evt   <= sample[i];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign btn_level[i] = level;
      assign btn_event[i] = evt;
   end

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_cnt_nxt;
   logic [CNT_W-1:0] press_cnt;
   logic             step_veto;
   logic             level1_prev;
   logic             release1;
   logic             toggle;
   logic             step_pulse;
   logic             step_mode_nxt;
   logic             clk_en_nxt;

   assign release1 = level1_prev & ~btn_level[1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= HOLD;
         hold_cnt    <= '0;
         step_mode   <= 1'b0;
         cpu_reset_n <= 1'b0;
         cpu_clk_en  <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_cnt_nxt;
         step_mode   <= step_mode_nxt;
         cpu_reset_n <= (state_nxt == ACTIVE);
         cpu_clk_en  <= clk_en_nxt;
      end
   end

   // A press is disqualified as a step once it turns long or is seen while the CPU is held.
   always_ff @(posedge clk) begin
      if (!reset) begin
         press_cnt   <= '0;
         step_veto   <= 1'b0;
         level1_prev <= 1'b0;
      end else begin
         level1_prev <= btn_level[1];
         if (!btn_level[1]) begin
            press_cnt <= '0;
            step_veto <= 1'b0;
         end else begin
            if (press_cnt != LONG_MAX) begin
               press_cnt <= press_cnt + 1'b1;
            end
            if (press_cnt == LONG_LAST || state == HOLD) begin
               step_veto <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      hold_cnt_nxt  = hold_cnt;
      toggle        = btn_level[1] && (press_cnt == LONG_LAST) && !btn_event[0];
      step_pulse    = release1 && !step_veto && (state == ACTIVE) && step_mode
                      && !btn_event[0];
      step_mode_nxt = step_mode ^ toggle;

      if (btn_event[0]) begin
         state_nxt    = HOLD;
         hold_cnt_nxt = '0;
      end else begin
         case (state)
            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nxt    = ACTIVE;
                  hold_cnt_nxt = '0;
               end else begin
                  hold_cnt_nxt = hold_cnt + 1'b1;
               end
            end
            ACTIVE: begin
               state_nxt = ACTIVE;
            end
            default: begin
               state_nxt    = HOLD;
               hold_cnt_nxt = '0;
            end
         endcase
      end

      clk_en_nxt = (state_nxt == HOLD) || !step_mode_nxt || step_pulse;
   end

endmodule

// File: tb/tb_run_control_unit.sv
// Directed bench for run_control_unit with short debounce/hold/long-press constants.
module tb_run_control_unit;

   localparam int NB = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] btn;
   logic          cpu_reset_n;
   logic          cpu_clk_en;
   logic          step_mode;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_event;

   int n_chk  = 0;
   int n_pass = 0;
   int evts;
   int lows;
   int pulses;
   int pulse_at;

   run_control_unit #(
      .NUM_BTNS         (NB),
      .DEBOUNCE_CYCLES  (4),
      .RESET_HOLD_CYCLES(3),
      .LONG_PRESS_CYCLES(20),
      .CNT_W            (24)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .cpu_reset_n(cpu_reset_n),
      .cpu_clk_en (cpu_clk_en),
      .step_mode  (step_mode),
      .btn_level  (btn_level),
      .btn_event  (btn_event)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b0;
      btn   = '1;

      // 1: power-on reset sequence
      tick(2);
      reset = 1'b1;
      check("rst_cpu_reset_n", 32'(cpu_reset_n), 0);
      check("rst_clk_en", 32'(cpu_clk_en), 0);
      check("rst_step_mode", 32'(step_mode), 0);
      check("rst_level", 32'(btn_level), 0);
      check("rst_event", 32'(btn_event), 0);
      tick(1);
      check("por_t1_reset_n", 32'(cpu_reset_n), 0);
      check("por_t1_clk_en", 32'(cpu_clk_en), 1);
      tick(1);
      check("por_t2_reset_n", 32'(cpu_reset_n), 0);
      tick(1);
      check("por_t3_reset_n", 32'(cpu_reset_n), 1);
      lows = 0;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         if (!cpu_clk_en) lows++;
      end
      check("run_clk_en_gaps", lows, 0);
      check("idle_level", 32'(btn_level), 0);

      // 2: bouncing reset button
      evts = 0;
      btn[0] = 1'b0;
      tick(1);
      evts += int'(btn_event[0]);
      btn[0] = 1'b1;
      tick(1);
      evts += int'(btn_event[0]);
      btn[0] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         evts += int'(btn_event[0]);
      end
      check("bounce_no_event", evts, 0);
      check("bounce_level_t6", 32'(btn_level[0]), 0);
      tick(1);
      check("b0_level_t7", 32'(btn_level[0]), 1);
      check("b0_event_t7", 32'(btn_event[0]), 1);
      check("b0_reset_n_t7", 32'(cpu_reset_n), 1);
      tick(1);
      check("b0_event_t8", 32'(btn_event[0]), 0);
      check("b0_reset_n_t8", 32'(cpu_reset_n), 0);
      check("b0_clk_en_hold", 32'(cpu_clk_en), 1);
      lows = 1;
      for (int k = 9; k <= 12; k++) begin
         tick(1);
         if (!cpu_reset_n) lows++;
      end
      check("b0_hold_len", lows, 3);
      btn[0] = 1'b1;
      evts = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         evts += int'(btn_event[0]);
      end
      check("b0_release_no_event", evts, 0);
      check("b0_released_level", 32'(btn_level[0]), 0);

      // 3: long press toggles into STEP mode
      btn[1] = 1'b0;
      tick(7);
      check("b1_level_t7", 32'(btn_level[1]), 1);
      check("b1_event_t7", 32'(btn_event[1]), 1);
      tick(19);
      check("long_step_t26", 32'(step_mode), 0);
      tick(1);
      check("long_step_t27", 32'(step_mode), 1);
      tick(10);
      check("long_step_t37", 32'(step_mode), 1);
      btn[1] = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if (cpu_clk_en) pulses++;
      end
      check("long_release_pulses", pulses, 0);
      check("long_release_level", 32'(btn_level[1]), 0);

      // 4: short press in STEP mode gives one pulse
      btn[1] = 1'b0;
      pulses = 0;
      pulse_at = -1;
      for (int k = 1; k <= 25; k++) begin
         tick(1);
         if (cpu_clk_en) begin
            pulses++;
            pulse_at = k;
         end
         if (k == 10) btn[1] = 1'b1;
      end
      check("short_pulses", pulses, 1);
      check("short_pulse_time", pulse_at, 18);
      check("short_step_mode", 32'(step_mode), 1);

      // 5: reset press coincides with step release
      btn[1] = 1'b0;
      tick(8);
      btn[0] = 1'b0;
      btn[1] = 1'b1;
      tick(7);
      check("coinc_event0", 32'(btn_event[0]), 1);
      check("coinc_level1", 32'(btn_level[1]), 0);
      tick(1);
      check("coinc_reset_n_t8", 32'(cpu_reset_n), 0);
      check("coinc_step_t8", 32'(step_mode), 1);
      tick(3);
      check("coinc_reset_n_t11", 32'(cpu_reset_n), 1);
      check("coinc_clk_en_t11", 32'(cpu_clk_en), 0);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (cpu_clk_en) pulses++;
      end
      check("coinc_no_pulse", pulses, 0);
      btn[0] = 1'b1;
      tick(10);

      // 6: reset port asserted mid long-press
      btn[1] = 1'b0;
      tick(17);
      reset = 1'b0;
      tick(2);
      check("midrst_step", 32'(step_mode), 0);
      check("midrst_level", 32'(btn_level), 0);
      check("midrst_reset_n", 32'(cpu_reset_n), 0);
      check("midrst_clk_en", 32'(cpu_clk_en), 0);
      reset = 1'b1;
      evts = 0;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         evts += int'(btn_event[1]);
      end
      check("midrst_no_early_event", evts, 0);
      check("midrst_level_t6", 32'(btn_level[1]), 0);
      tick(1);
      check("midrst_event_t7", 32'(btn_event[1]), 1);
      check("midrst_reset_n_t7", 32'(cpu_reset_n), 1);
      tick(19);
      check("midrst_step_t26", 32'(step_mode), 0);
      tick(1);
      check("midrst_step_t27", 32'(step_mode), 1);
      btn[1] = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         if (cpu_clk_en) pulses++;
      end
      check("midrst_release_pulses", pulses, 0);

      // 7: extra button only reports level and event
      btn[2] = 1'b0;
      tick(7);
      check("b2_level", 32'(btn_level[2]), 1);
      check("b2_event", 32'(btn_event[2]), 1);
      tick(1);
      check("b2_event_off", 32'(btn_event[2]), 0);
      check("b2_reset_n", 32'(cpu_reset_n), 1);
      check("b2_step", 32'(step_mode), 1);
      btn[2] = 1'b1;
      tick(10);
      check("b2_released", 32'(btn_level[2]), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
